// File: rtl/tristate_register_pkg.sv
// Shared constants for the register-file storage entry.
package tristate_register_pkg;

    localparam int WORD_WIDTH = 32;

endpackage

// File: rtl/tristate_register_dffe_sync.sv
// Single-bit storage cell (dffe_sync): D flip-flop with synchronous
// active-high reset and write enable. Powers up holding 0.
module tristate_register_dffe_sync (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    logic q_q = 1'b0;
    logic q_d;

    // Next value: hold unless the write enable selects new data.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    // Storage flop; reset wins over any write on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tristate_register.sv
// One register-file entry: clocked write port, two independently
// enabled tri-state read ports that show the stored word.
module tristate_register
    import tristate_register_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    output tri   [WIDTH-1:0] data_out1,
    output tri   [WIDTH-1:0] data_out2,
    input  logic             clk,
    input  logic             input_enable,
    input  logic             output_enable1,
    input  logic             output_enable2,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in
);

    logic [WIDTH-1:0] q;

    // One storage cell per bit; the read ports see only the stored
    // value, so a write becomes visible after the edge, never before.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tristate_register_dffe_sync u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (input_enable),
            .d     (data_in[i]),
            .q     (q[i])
        );
    end

    // Disabled ports float every bit so many entries can share a bus.
    assign data_out1 = output_enable1 ? q : {WIDTH{1'bz}};
    assign data_out2 = output_enable2 ? q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_register.sv
// Bench for tristate_register: directed steps followed by random traffic
// checked against a behavioural model of the stored word.
module tb_tristate_register;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         input_enable = 1'b0;
    logic         output_enable1 = 1'b0;
    logic         output_enable2 = 1'b0;
    logic [W-1:0] data_in = '0;
    wire  [W-1:0] data_out1;
    wire  [W-1:0] data_out2;

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [W-1:0] model_q = '0;

    tristate_register #(.WIDTH(W)) dut (
        .data_out1      (data_out1),
        .data_out2      (data_out2),
        .clk            (clk),
        .input_enable   (input_enable),
        .output_enable1 (output_enable1),
        .output_enable2 (output_enable2),
        .reset          (reset),
        .data_in        (data_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        logic [W-1:0] exp1;
        logic [W-1:0] exp2;
        exp1 = output_enable1 ? model_q : {W{1'bz}};
        exp2 = output_enable2 ? model_q : {W{1'bz}};
        n_cmp++;
        assert (data_out1 === exp1) else begin
            n_fail++;
            $error("FAIL %s port1 got=%h want=%h", tag, data_out1, exp1);
        end
        n_cmp++;
        assert (data_out2 === exp2) else begin
            n_fail++;
            $error("FAIL %s port2 got=%h want=%h", tag, data_out2, exp2);
        end
    endtask

    // One rising edge; the model applies the write rules to the inputs
    // present at that edge, then outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        if (reset)             model_q = '0;
        else if (input_enable) model_q = data_in;
        #1;
    endtask

    initial begin
        output_enable1 = 1'b1;
        output_enable2 = 1'b1;
        #1;
        check("powerup");

        reset = 1'b1;
        tick();
        check("reset");
        reset = 1'b0;

        data_in = 32'h0000_00EA;
        input_enable = 1'b1;
        #1;
        check("no_bypass");
        tick();
        check("write_ea");
        n_cmp++;
        assert (data_out1 === 32'h0000_00EA) else begin
            n_fail++;
            $error("FAIL write_ea_const got=%h want=%h", data_out1, 32'h0000_00EA);
        end

        input_enable = 1'b0;
        data_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold");
        end

        output_enable2 = 1'b0;
        #1;
        check("tri_p2_off");
        output_enable1 = 1'b0;
        output_enable2 = 1'b1;
        #1;
        check("tri_p1_off");
        output_enable2 = 1'b0;
        #1;
        check("tri_both_off");
        output_enable1 = 1'b1;
        output_enable2 = 1'b1;

        reset = 1'b1;
        input_enable = 1'b1;
        data_in = 32'h1234_5678;
        tick();
        check("reset_prio");
        n_cmp++;
        assert (data_out2 === 32'h0000_0000) else begin
            n_fail++;
            $error("FAIL reset_prio_const got=%h want=%h", data_out2, 32'h0);
        end
        reset = 1'b0;

        data_in = 32'hFFFF_FFFF;
        tick();
        check("all_ones");
        data_in = 32'h8000_0001;
        tick();
        check("msb_lsb");

        for (int i = 0; i < 300; i++) begin
            reset          = ($urandom_range(0, 9) == 0);
            input_enable   = $urandom_range(0, 1) == 1;
            output_enable1 = $urandom_range(0, 1) == 1;
            output_enable2 = $urandom_range(0, 1) == 1;
            data_in        = $urandom;
            #1;
            check("rand_pre");
            tick();
            check("rand_post");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
